// File: rtl/freq_pkg.sv
// Shared definitions for the frequency-encoded link: FSM states and default sizing
// used by the gate decoder and the loopback checker.
package freq_pkg;

  localparam int GATE_W = 24;
  localparam logic [GATE_W-1:0] GATE_CYCLES_DEF = 24'd1_000_000;
  localparam int DATA_W_DEF = 8;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    REPORT  = 2'd3
  } state_e;

endpackage

// File: rtl/freq_edge_sync.sv
// Synchronizes an asynchronous pulse stream into clk and emits a one-cycle strobe
// per rising edge; strobe lags the pin by SYNC_STAGES+1 cycles.
module freq_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // NOTE: every flop in the chain uses <= so each stage samples the previous
  // stage's old value; blocking assignments would collapse the chain to one flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/freq_gate_decoder.sv
// Counts synchronized rising edges of pulse_in over a fixed gate window aligned to
// an edge and reports one count word per window with a single-cycle valid strobe.
module freq_gate_decoder
  import freq_pkg::*;
#(
  parameter logic [GATE_W-1:0] GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int                SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int                DATA_W      = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              pulse_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              overflow,
  output logic              no_signal,
  output logic              busy
);

  localparam logic [GATE_W-1:0] GATE_LAST = GATE_CYCLES - GATE_W'(1);
  localparam logic [DATA_W-1:0] CNT_MAX   = '1;

  state_e              state_q;
  logic [GATE_W-1:0]   gate_cnt_q;
  logic [DATA_W-1:0]   edge_cnt_q;
  logic                ovf_flag_q;
  logic                rise;
  logic                gate_done;

  freq_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (pulse_in),
    .rise     (rise)
  );

  assign gate_done = (gate_cnt_q == GATE_LAST);
  assign busy      = (state_q == ARM) || (state_q == MEASURE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      ovf_flag_q <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      no_signal  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (!ena) begin
        // Abort drops the partial window; the reported outputs keep their last values.
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            state_q    <= ARM;
            gate_cnt_q <= '0;
          end
          ARM: begin
            if (rise) begin
              state_q    <= MEASURE;
              gate_cnt_q <= '0;
              edge_cnt_q <= '0;
              ovf_flag_q <= 1'b0;
            end else if (gate_done) begin
              gate_cnt_q <= '0;
              data_out   <= '0;
              overflow   <= 1'b0;
              no_signal  <= 1'b1;
              data_valid <= 1'b1;
            end else begin
              gate_cnt_q <= gate_cnt_q + GATE_W'(1);
            end
          end
          MEASURE: begin
            if (rise) begin
              if (edge_cnt_q == CNT_MAX) ovf_flag_q <= 1'b1;
              else                       edge_cnt_q <= edge_cnt_q + DATA_W'(1);
            end
            if (gate_done) state_q    <= REPORT;
            else           gate_cnt_q <= gate_cnt_q + GATE_W'(1);
          end
          REPORT: begin
            data_out   <= edge_cnt_q;
            overflow   <= ovf_flag_q;
            no_signal  <= 1'b0;
            data_valid <= 1'b1;
            // The next window opens here, so an edge in this cycle is its first count.
            edge_cnt_q <= DATA_W'(rise);
            ovf_flag_q <= 1'b0;
            gate_cnt_q <= '0;
            state_q    <= MEASURE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_freq_gate_decoder.sv
// Directed bench for freq_gate_decoder: two instances (100- and 1000-cycle gates)
// with a scoreboard queue per instance checked on each data_valid strobe.
module tb_freq_gate_decoder;

  typedef struct {
    logic [7:0] data;
    logic       ovf;
    logic       nos;
    int         gap;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       ena_a, ena_b;
  logic       man_a, man_b, gen_a, gen_b;
  logic       pulse_a, pulse_b;
  int         per_a, per_b;
  logic [7:0] data_out_a, data_out_b;
  logic       valid_a, valid_b, ovf_a, ovf_b, nos_a, nos_b, busy_a, busy_b;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  int   cyc = 0;
  int   last_a = 0;
  int   last_b = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   n0;

  assign pulse_a = (per_a != 0) ? gen_a : man_a;
  assign pulse_b = (per_b != 0) ? gen_b : man_b;

  freq_gate_decoder #(.GATE_CYCLES(24'd100), .SYNC_STAGES(2), .DATA_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena_a), .pulse_in(pulse_a),
    .data_out(data_out_a), .data_valid(valid_a), .overflow(ovf_a),
    .no_signal(nos_a), .busy(busy_a)
  );

  freq_gate_decoder #(.GATE_CYCLES(24'd1000), .SYNC_STAGES(2), .DATA_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena_b), .pulse_in(pulse_b),
    .data_out(data_out_b), .data_valid(valid_b), .overflow(ovf_b),
    .no_signal(nos_b), .busy(busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Free-running square waves, updated on the falling edge.
  initial begin
    int ph_a, ph_b;
    ph_a = 0; ph_b = 0; gen_a = 1'b0; gen_b = 1'b0;
    forever begin
      @(negedge clk);
      if (per_a != 0) begin
        ph_a  = (ph_a + 1 >= per_a) ? 0 : ph_a + 1;
        gen_a = (ph_a < per_a / 2);
      end
      if (per_b != 0) begin
        ph_b  = (ph_b + 1 >= per_b) ? 0 : ph_b + 1;
        gen_b = (ph_b < per_b / 2);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic o, input logic n, input int g);
    exp_t e;
    e.data = d; e.ovf = o; e.nos = n; e.gap = g;
    return e;
  endfunction

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_drain_a(input int limit);
    int n = 0;
    while (q_a.size() != 0 && n < limit) begin @(negedge clk); n++; end
    check("a_drain_timeout", q_a.size(), 0);
  endtask

  task automatic wait_drain_b(input int limit);
    int n = 0;
    while (q_b.size() != 0 && n < limit) begin @(negedge clk); n++; end
    check("b_drain_timeout", q_b.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid_a === 1'b1) begin
      check("a_expected_valid", q_a.size() != 0, 1);
      if (q_a.size() != 0) begin
        e_a = q_a.pop_front();
        check("a_data", data_out_a, e_a.data);
        check("a_overflow", ovf_a, e_a.ovf);
        check("a_no_signal", nos_a, e_a.nos);
        if (e_a.gap != 0) check("a_valid_gap", cyc - last_a, e_a.gap);
      end
      last_a = cyc;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid_b === 1'b1) begin
      check("b_expected_valid", q_b.size() != 0, 1);
      if (q_b.size() != 0) begin
        e_b = q_b.pop_front();
        check("b_data", data_out_b, e_b.data);
        check("b_overflow", ovf_b, e_b.ovf);
        check("b_no_signal", nos_b, e_b.nos);
        if (e_b.gap != 0) check("b_valid_gap", cyc - last_b, e_b.gap);
      end
      last_b = cyc;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d",
             vectors, miscompares);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ena_a = 1'b0; ena_b = 1'b0;
    per_a = 0; per_b = 0; man_a = 1'b0; man_b = 1'b0;

    // Reset holds every output low while the pins toggle.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      man_a = ~man_a; man_b = ~man_b;
    end
    @(negedge clk);
    check("rst_a_data", data_out_a, 0);  check("rst_b_data", data_out_b, 0);
    check("rst_a_valid", valid_a, 0);    check("rst_b_valid", valid_b, 0);
    check("rst_a_ovf", ovf_a, 0);        check("rst_b_ovf", ovf_b, 0);
    check("rst_a_nos", nos_a, 0);        check("rst_b_nos", nos_b, 0);
    check("rst_a_busy", busy_a, 0);      check("rst_b_busy", busy_b, 0);
    man_a = 1'b0; man_b = 1'b0;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_a_busy", busy_a, 0);     check("idle_b_busy", busy_b, 0);
    check("idle_a_valid", valid_a, 0);

    // Nominal: period 10 over a 100-cycle gate; reports every 101 cycles.
    per_a = 10;
    repeat (5) @(negedge clk);
    ena_a = 1'b1;
    q_a.push_back(mk(8'd10, 1'b0, 1'b0, 0));
    q_a.push_back(mk(8'd10, 1'b0, 1'b0, 101));
    q_a.push_back(mk(8'd10, 1'b0, 1'b0, 101));
    wait_drain_a(500);
    check("nom_a_busy", busy_a, 1);

    // Abort mid-window: no report, outputs held, then re-align.
    repeat (50) @(negedge clk);
    ena_a = 1'b0;
    @(negedge clk);
    check("abort_a_busy", busy_a, 0);
    check("abort_a_data", data_out_a, 10);
    repeat (150) @(negedge clk);
    check("abort_a_data_held", data_out_a, 10);
    check("abort_a_nos_held", nos_a, 0);
    ena_a = 1'b1;
    q_a.push_back(mk(8'd10, 1'b0, 1'b0, 0));
    wait_drain_a(400);
    ena_a = 1'b0;

    // No signal: IDLE + 100 ARM cycles to the first timeout, then every 100.
    per_a = 0; man_a = 1'b0;
    repeat (10) @(negedge clk);
    last_a = cyc;
    ena_a = 1'b1;
    q_a.push_back(mk(8'd0, 1'b0, 1'b1, 101));
    q_a.push_back(mk(8'd0, 1'b0, 1'b1, 100));
    q_a.push_back(mk(8'd0, 1'b0, 1'b1, 100));
    wait_drain_a(500);
    check("nos_a_busy_arm", busy_a, 1);
    ena_a = 1'b0;

    // Saturation on the 1000-cycle gate, then a slower stream after re-arming.
    per_b = 2;
    repeat (5) @(negedge clk);
    ena_b = 1'b1;
    q_b.push_back(mk(8'd255, 1'b1, 1'b0, 0));
    q_b.push_back(mk(8'd255, 1'b1, 1'b0, 1001));
    wait_drain_b(2500);
    check("sat_b_busy", busy_b, 1);
    ena_b = 1'b0;
    per_b = 20;
    repeat (10) @(negedge clk);
    check("sat_b_data_held", data_out_b, 255);
    check("sat_b_ovf_held", ovf_b, 1);
    ena_b = 1'b1;
    q_b.push_back(mk(8'd50, 1'b0, 1'b0, 0));
    q_b.push_back(mk(8'd50, 1'b0, 1'b0, 1001));
    wait_drain_b(2500);
    ena_b = 1'b0;

    // Boundary: pin rise at n0 aligns (seen 4 cycles later); a rise at n0+100 lands
    // in window cycle 100; a rise at n0+202 lands in the following REPORT cycle.
    per_a = 0; man_a = 1'b0;
    repeat (10) @(negedge clk);
    ena_a = 1'b1;
    repeat (5) @(negedge clk);
    n0 = cyc;
    man_a = 1'b1;
    wait_until(n0 + 50);  man_a = 1'b0;
    wait_until(n0 + 100); man_a = 1'b1;
    q_a.push_back(mk(8'd1, 1'b0, 1'b0, 0));
    wait_until(n0 + 150); man_a = 1'b0;
    q_a.push_back(mk(8'd0, 1'b0, 1'b0, 101));
    wait_until(n0 + 202); man_a = 1'b1;
    q_a.push_back(mk(8'd1, 1'b0, 1'b0, 101));
    wait_until(n0 + 250); man_a = 1'b0;
    wait_drain_a(300);

    // Asynchronous reset mid-window clears outputs without waiting for a clock.
    repeat (30) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_a_data", data_out_a, 0);
    check("arst_a_busy", busy_a, 0);
    check("arst_a_valid", valid_a, 0);
    check("arst_b_data", data_out_b, 0);
    ena_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_a_busy", busy_a, 0);
    check("post_rst_a_pending", q_a.size(), 0);
    check("post_rst_b_pending", q_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
